wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one CHUNK-bit ripple adder (CHUNK single-bit full adders) over WIDTH/CHUNK cycles, with the carry held in a register between chunks. It serves as the final carry-propagate stage after the Wallace reduction in the 1024-bit multiplier: the reduced sum and carry rows are summed here without building a 1024-bit combinational carry chain.

## Interface
- WIDTH, 1024: operand and result width; must be a nonzero multiple of CHUNK.
- CHUNK, 64: bits added per cycle; number of chunks N = WIDTH/CHUNK.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- cin  in  1  carry into bit 0; sampled on the accepting edge.
- ready  out  1  high in IDLE; the block can accept start.
- done  out  1  one-cycle pulse; sum and cout are valid.
- sum  out  WIDTH  result register; holds its value until the next accepted start.
- cout  out  1  carry out of bit WIDTH-1; holds with sum.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: ready=1. On start=1, latch a, b and cin (carry register = cin), set idx=0, clear sum and cout, and go to RUN.
  - RUN: each cycle compute {c, s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry. Write s into sum[idx*CHUNK +: CHUNK] and set carry = c.
    - If idx = N-1: set cout = c and go to DONE.
    - Otherwise idx = idx+1.
  - DONE: done=1 for exactly this cycle, then return to IDLE.
- start while ready=0 is ignored; there is no queueing.
- Arithmetic: the result is the exact (WIDTH+1)-bit sum {cout, sum} = a + b + cin, with no truncation.
- Reset values: state=IDLE, ready=1, done=0, sum=0, cout=0, carry=0, idx=0.
- Reset mid-operation: the in-flight addition is abandoned with no done pulse. ready=1 on the first cycle after rst deasserts.
- Latched operands are internal copies, so a and b may change after acceptance without affecting the result.

## Timing
- Accept edge E0 (start=1, ready=1): ready=0 from E0.
- Chunk k is written at edge E(k+1), for k = 0..N-1.
- cout is valid and state=DONE after EN; done=1 during the cycle EN..E(N+1).
- ready=1 again after E(N+1), so the next start can be accepted at E(N+2).
- Issue interval is N+2 cycles; latency from start to done is N+1 cycles. With the defaults, N=16: done is high 17 cycles after the accept edge.
- start held high continuously starts back-to-back operations every N+2 cycles.

## Structure
- Shared package:
  - state enum (IDLE, RUN, DONE);
  - derived constant N = WIDTH/CHUNK and the idx width clog2(N), minimum 1;
  - an elaboration-time check that WIDTH mod CHUNK = 0.
- Sub-module chunk_ripple_add (CHUNK parameter; inputs x, y, ci; outputs s, co), built as a ripple of CHUNK single-bit full adders. It is purely combinational.
- The top level contains the FSM, idx counter, carry register, operand registers and sum register.
- For N=1, DONE is reached after a single RUN cycle.

## Test plan
The bench uses WIDTH=16, CHUNK=4 (N=4).
- Basic: a=0x1234, b=0x1111, cin=0 -> done 5 cycles after accept; sum=0x2345, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. The carry must cross all 4 chunks.
- Overflow: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Busy rejection:
  - start a=1, b=1, then pulse start with a=0xAAAA during RUN and change a/b inputs -> single done with sum=0x0002, cout=0;
  - no second done;
  - ready stays low until done+1.
- Reset mid-RUN: assert rst two cycles after accept -> no done; sum=0, cout=0, ready=1. A following start with a=0x0F0F, b=0x00F1, cin=0 gives sum=0x1000, cout=0.
- Back-to-back and random: start held high for 100 random operand sets -> exactly one done per N+2 cycles; {cout, sum} matches a+b+cin every time.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide_add_seq carry-propagate sequencer:
// FSM state encoding, chunk-geometry helpers and the one-bit full adder.
package wide_add_seq_pkg;

    localparam int DEF_WIDTH = 1024;
    localparam int DEF_CHUNK = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of chunk passes needed to cover the whole operand.
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index counter width; never narrower than one bit so N=1 still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operand width must be a nonzero whole number of chunks.
    function automatic bit geometry_ok(input int width, input int chunk);
        return (width > 0) && (chunk > 0) && ((width % chunk) == 0);
    endfunction

    // One-bit full adder, result packed as {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic c;
        s = x ^ y ^ ci;
        c = (x & y) | (ci & (x ^ y));
        return {c, s};
    endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result bundle between a requester and the wide_add_seq block.
interface wide_add_seq_if
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  ready, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, done, sum, cout
    );
endinterface

// File: rtl/wide_add_seq_chunk_ripple_add.sv
// Purely combinational CHUNK-bit ripple-carry adder built from single-bit
// full adders; the top level reuses it once per chunk.
module chunk_ripple_add
    import wide_add_seq_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic       carry_s;
    logic [1:0] fa_s;

    // Ripple the carry through CHUNK full adders, LSB first.
    always_comb begin
        carry_s = ci;
        fa_s    = 2'b00;
        s       = '0;
        for (int i = 0; i < CHUNK; i++) begin
            fa_s    = full_add(x[i], y[i], carry_s);
            s[i]    = fa_s[0];
            carry_s = fa_s[1];
        end
        co = carry_s;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: sums two WIDTH-bit operands one CHUNK-bit slice
// per cycle through a single shared ripple adder, carrying between slices
// in a register so no WIDTH-bit combinational carry chain is built.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);

    localparam int                N        = num_chunks(WIDTH, CHUNK);
    localparam int                IDXW     = idx_width(N);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(N - 1);
    localparam logic [31:0]       CHUNK_U  = 32'(CHUNK);

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("wide_add_seq: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_t            state_r;
    logic              ready_r;
    logic              done_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;

    logic [31:0]       base_s;
    logic [CHUNK-1:0]  x_s;
    logic [CHUNK-1:0]  y_s;
    logic [CHUNK-1:0]  s_s;
    logic              co_s;

    // Select the current chunk of the latched operands.
    always_comb begin
        base_s = 32'(idx_r) * CHUNK_U;
        x_s    = a_r[base_s +: CHUNK];
        y_s    = b_r[base_s +: CHUNK];
    end

    chunk_ripple_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .x  (x_s),
        .y  (y_s),
        .ci (carry_r),
        .s  (s_s),
        .co (co_s)
    );

    // Sequencer FSM with operand latch, chunk index, carry and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_r[base_s +: CHUNK] <= s_s;
                    carry_r                <= co_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= co_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with WIDTH=16, CHUNK=4 (N=4).
module tb_wide_add_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef logic [WIDTH:0] res_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wide_add_seq_if #(.WIDTH(WIDTH)) bus ();

    wide_add_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   errors   = 0;
    res_t exp_q[$];
    int   acc_q[$];
    int   cyc      = 0;
    int   accepts  = 0;
    int   dones    = 0;
    int   aborted  = 0;
    int   last_acc = -1;
    bit   b2b      = 1'b0;
    res_t last_res = '0;

    task automatic chk(input string name, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Record each accepted request and push its reference result a+b+cin.
    always @(posedge clk) begin
        if (rst !== 1'b1 && bus.start === 1'b1 && bus.ready === 1'b1) begin
            exp_q.push_back(res_t'(bus.a) + res_t'(bus.b) + res_t'(bus.cin));
            acc_q.push_back(cyc);
            if (b2b && last_acc >= 0)
                chk("issue_interval", res_t'(cyc - last_acc), res_t'(N + 2));
            last_acc = cyc;
            accepts++;
        end
        cyc++;
    end

    // Monitor: check ready every cycle, pop and compare on each done.
    always begin
        int acc;
        res_t e;
        @(posedge clk);
        #2;
        if (rst !== 1'b1) begin
            chk("ready", res_t'(bus.ready), res_t'(exp_q.size() == 0));
            if (bus.done === 1'b1) begin
                dones++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done (nothing in flight)");
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    last_res = {bus.cout, bus.sum};
                    chk("result", last_res, e);
                    chk("latency", res_t'(cyc - acc), res_t'(N + 1));
                end
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_wait_ready", res_t'(bus.ready), res_t'(1));
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", res_t'(exp_q.size()), res_t'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int target;
        bit ok;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", res_t'(bus.ready), res_t'(1));
        chk("reset_done",  res_t'(bus.done),  res_t'(0));
        chk("reset_sum",   res_t'(bus.sum),   res_t'(0));
        chk("reset_cout",  res_t'(bus.cout),  res_t'(0));
        rst = 1'b0;

        issue(16'h1234, 16'h1111, 1'b0);
        wait_idle();
        chk("basic", last_res, 17'h02345);

        issue(16'hFFFF, 16'h0000, 1'b1);
        wait_idle();
        chk("full_ripple", last_res, 17'h10000);

        issue(16'hFFFF, 16'hFFFF, 1'b1);
        wait_idle();
        chk("overflow", last_res, 17'h1FFFF);

        // Busy rejection: start pulse and input changes during RUN are ignored.
        d0 = dones;
        issue(16'h0001, 16'h0001, 1'b0);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        wait_idle();
        repeat (N + 4) @(negedge clk);
        chk("busy_result", last_res, 17'h00002);
        chk("busy_single_done", res_t'(dones - d0), res_t'(1));

        // Reset two cycles after accept abandons the addition.
        issue(16'h00FF, 16'h0F01, 1'b1);
        @(negedge clk);
        d0  = dones;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        aborted++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_sum",   res_t'(bus.sum),   res_t'(0));
        chk("rst_mid_cout",  res_t'(bus.cout),  res_t'(0));
        chk("rst_mid_ready", res_t'(bus.ready), res_t'(1));
        repeat (N + 4) @(negedge clk);
        chk("rst_mid_no_done", res_t'(dones - d0), res_t'(0));
        issue(16'h0F0F, 16'h00F1, 1'b0);
        wait_idle();
        chk("after_reset", last_res, 17'h01000);

        // Back-to-back random operations with start held high.
        b2b       = 1'b1;
        last_acc  = -1;
        target    = accepts + 100;
        ok        = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.cin   = 1'($urandom);
        for (int i = 0; i < 100 * (N + 2) + 40; i++) begin
            @(negedge clk);
            if (accepts >= target) begin
                ok = 1'b1;
                break;
            end
            bus.a   = WIDTH'($urandom);
            bus.b   = WIDTH'($urandom);
            bus.cin = 1'($urandom);
        end
        bus.start = 1'b0;
        b2b       = 1'b0;
        if (!ok) chk("b2b_accept_count", res_t'(accepts), res_t'(target));
        wait_idle();
        repeat (N + 4) @(negedge clk);

        chk("done_count", res_t'(dones), res_t'(accepts - aborted));
        chk("queue_empty", res_t'(exp_q.size()), res_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
